pc_ram_burst_ctrl: RTL and testbench

//  Parametrised address-counter + single-port RAM controller; successor to the lab PC->RAM pairing.

---
 rtl/pc_ram_pkg.sv | 14 +
 rtl/sp_ram.sv | 31 +++
 rtl/pc_ram_burst_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pc_ram_burst_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_ram_pkg.sv
// Shared types and constants for the PC/RAM burst controller and its bench.
package pc_ram_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        VERIFY = 2'd2,
        DRAIN  = 2'd3
    } burst_state_t;

    localparam logic MODE_FILL   = 1'b0;
    localparam logic MODE_VERIFY = 1'b1;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM, one-cycle read latency, old data on read-during-write.
module sp_ram #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; the array keeps its contents across reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[addr_i];
        end
    end

endmodule

// File: rtl/pc_ram_burst_ctrl.sv
// Address counter + RAM controller: manual step/load/inc/write plus burst FILL and VERIFY.
module pc_ram_burst_ctrl
    import pc_ram_pkg::*;
#(
    parameter int AW    = 8,
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step,
    input  logic             load,
    input  logic             inc,
    input  logic             wren,
    input  logic [DW-1:0]    din,
    input  logic             cmd_start,
    input  logic             cmd_mode,
    input  logic [AW-1:0]    burst_len,
    input  logic             cmd_abort,
    output logic [AW-1:0]    addr,
    output logic [DW-1:0]    q,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_cnt,
    output burst_state_t     dbg_state
);

    localparam logic [AW-1:0]    ADDR_ONE = AW'(1);
    localparam logic [DW-1:0]    DATA_ONE = DW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [AW:0]      REM_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]      REM_FULL = {1'b1, {AW{1'b0}}};

    burst_state_t     state_q, state_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [DW-1:0]    pat_q, pat_d;      // seed + idx of the word handled this cycle
    logic [AW:0]      rem_q, rem_d;      // words still to write / read, including this one
    logic [DW-1:0]    exp_q, exp_d;      // expected data travelling alongside the RAM read
    logic             cmp_vld_q, cmp_vld_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic             done_q, done_d;

    logic             ram_we;
    logic [DW-1:0]    ram_wdata;
    logic             mismatch;
    logic [CNT_W-1:0] err_inc;

    sp_ram #(.AW(AW), .DW(DW)) u_ram (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .we_i   (ram_we),
        .addr_i (addr_q),
        .wdata_i(ram_wdata),
        .rdata_o(q)
    );

    assign mismatch = cmp_vld_q && (q != exp_q);
    assign err_inc  = (err_q == '1) ? err_q : err_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pat_d     = pat_q;
        rem_d     = rem_q;
        exp_d     = exp_q;
        cmp_vld_d = 1'b0;
        err_d     = err_q;
        done_d    = 1'b0;
        ram_we    = 1'b0;
        ram_wdata = din;
        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    pat_d = din;
                    rem_d = (burst_len == '0) ? REM_FULL : {1'b0, burst_len};
                    if (cmd_mode == MODE_VERIFY) begin
                        err_d   = '0;
                        state_d = VERIFY;
                    end else begin
                        state_d = FILL;
                    end
                end else if (step) begin
                    ram_we = wren;
                    if (load) begin
                        addr_d = din[AW-1:0];
                    end else if (inc) begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            FILL: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    ram_we    = 1'b1;
                    ram_wdata = pat_q;
                    addr_d    = addr_q + ADDR_ONE;
                    pat_d     = pat_q + DATA_ONE;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            VERIFY: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    if (mismatch) begin
                        err_d = err_inc;
                    end
                    exp_d     = pat_q;
                    cmp_vld_d = 1'b1;
                    addr_d    = addr_q + ADDR_ONE;
                    pat_d     = pat_q + DATA_ONE;
                    rem_d     = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // The last read's data arrives here; compare it and finish.
                if (!cmd_abort && mismatch) begin
                    err_d = err_inc;
                end
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            pat_q     <= '0;
            rem_q     <= '0;
            exp_q     <= '0;
            cmp_vld_q <= 1'b0;
            err_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pat_q     <= pat_d;
            rem_q     <= rem_d;
            exp_q     <= exp_d;
            cmp_vld_q <= cmp_vld_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign addr      = addr_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err_cnt   = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_ram_burst_ctrl.sv
// Randomised bench for pc_ram_burst_ctrl: burst outcomes go through a scoreboard queue checked on done.
module tb_pc_ram_burst_ctrl;
    import pc_ram_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int CNT_W = 8;
    localparam int DEPTH = 256;
    localparam int EXP_W = 26;  // {busy cycles[9:0], final addr[7:0], err_cnt[7:0]}

    logic             clk = 1'b0;
    logic             reset_n;
    logic             step, load, inc, wren;
    logic [DW-1:0]    din;
    logic             cmd_start, cmd_mode;
    logic [AW-1:0]    burst_len;
    logic             cmd_abort;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    q;
    logic             busy, done;
    logic [CNT_W-1:0] err_cnt;
    burst_state_t     dbg_state;

    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    model_mem [DEPTH];
    logic [AW-1:0]    model_addr;
    int               model_err;
    int               n_cmp = 0;
    int               n_err = 0;

    always #5 clk = ~clk;

    pc_ram_burst_ctrl #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .step     (step),
        .load     (load),
        .inc      (inc),
        .wren     (wren),
        .din      (din),
        .cmd_start(cmd_start),
        .cmd_mode (cmd_mode),
        .burst_len(burst_len),
        .cmd_abort(cmd_abort),
        .addr     (addr),
        .q        (q),
        .busy     (busy),
        .done     (done),
        .err_cnt  (err_cnt),
        .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        step = 1'b0; load = 1'b0; inc = 1'b0; wren = 1'b0; din = '0;
        cmd_start = 1'b0; cmd_mode = 1'b0; burst_len = '0; cmd_abort = 1'b0;
    endtask

    task automatic manual_step(input logic l, input logic i, input logic w, input logic [7:0] d);
        step = 1'b1; load = l; inc = i; wren = w; din = d;
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic read_check(input logic [7:0] a);
        manual_step(1'b1, 1'b0, 1'b0, a);
        model_addr = a;
        @(posedge clk); #1;
        check("read_addr", addr, a);
        check("read_q", q, model_mem[a]);
    endtask

    // Runs one burst; the expected outcome is derived from the model and queued before driving.
    task automatic run_burst(input logic mode, input logic [7:0] base, input logic [7:0] len,
                             input logic [7:0] seed, input int abort_at);
        int words, cycles, n_wr, n_cw, errs, cyc;
        logic [7:0] a, e_addr;
        manual_step(1'b1, 1'b0, 1'b0, base);
        words = (len == 8'd0) ? DEPTH : int'(len);
        errs  = (mode == MODE_VERIFY) ? 0 : model_err;
        if (abort_at > 0) begin
            cycles = abort_at;
            n_wr   = abort_at - 1;
            n_cw   = (abort_at > 2) ? abort_at - 2 : 0;
        end else begin
            cycles = (mode == MODE_VERIFY) ? words + 1 : words;
            n_wr   = words;
            n_cw   = words;
        end
        for (int i = 0; i < n_wr && mode == MODE_FILL; i++) begin
            a = base + 8'(i);
            model_mem[a] = seed + 8'(i);
        end
        for (int i = 0; i < n_cw && mode == MODE_VERIFY; i++) begin
            a = base + 8'(i);
            if (model_mem[a] !== seed + 8'(i) && errs < 255) errs++;
        end
        e_addr     = base + 8'(n_wr);
        model_addr = e_addr;
        model_err  = errs;
        exp_q.push_back({10'(cycles), e_addr, 8'(errs)});

        cmd_start = 1'b1; cmd_mode = mode; burst_len = len; din = seed;
        @(posedge clk); #1;
        cyc = 1;
        while (busy && cyc <= 600) begin
            cmd_abort = (cyc == abort_at);
            step      = 1'($urandom);
            load      = 1'($urandom);
            inc       = 1'($urandom);
            wren      = 1'($urandom);
            din       = 8'($urandom);
            cmd_start = 1'($urandom);
            cmd_mode  = 1'($urandom);
            burst_len = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        clear_inputs();
        if (cyc > 600) check("burst_timeout", 32'(cyc), 32'd600);
    endtask

    task automatic manual_ops(input int n);
        logic s, l, i_r, w;
        logic [7:0] d, exp_qv;
        for (int k = 0; k < n; k++) begin
            s = 1'($urandom_range(0, 3) != 0);
            l = 1'($urandom_range(0, 3) == 0);
            i_r = 1'($urandom);
            w = 1'($urandom);
            d = 8'($urandom);
            step = s; load = l; inc = i_r; wren = w; din = d;
            exp_qv = model_mem[model_addr];
            if (s) begin
                if (w) model_mem[model_addr] = d;
                if (l) model_addr = d;
                else if (i_r) model_addr = model_addr + 8'd1;
            end
            @(posedge clk); #1;
            check("manual_addr", addr, model_addr);
            check("manual_q", q, exp_qv);
        end
        clear_inputs();
    endtask

    // Monitor: every done pulse pops one expected burst outcome.
    initial begin
        int busy_cyc = 0;
        logic prev_done = 1'b0;
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                busy_cyc  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cyc++;
                if (done) begin
                    check("done_single_cycle", 32'(prev_done), 32'd0);
                    check("busy_low_with_done", 32'(busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        check("done_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("burst_busy_cycles", 32'(busy_cyc), 32'(e[25:16]));
                        check("burst_addr", addr, 32'(e[15:8]));
                        check("burst_err_cnt", err_cnt, 32'(e[7:0]));
                    end
                    busy_cyc = 0;
                end
                prev_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       m;
        logic [7:0] b, l, s, vs;
        int         k;
        reset_n = 1'b0;
        clear_inputs();
        model_addr = '0;
        model_err  = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_addr", addr, 0);
        check("reset_q", q, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err_cnt", err_cnt, 0);
        check("reset_state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Manual load / write / reload, read back one cycle later.
        manual_step(1'b1, 1'b0, 1'b0, 8'h10);
        manual_step(1'b0, 1'b0, 1'b1, 8'hA5);
        manual_step(1'b1, 1'b0, 1'b0, 8'h10);
        @(posedge clk); #1;
        check("t1_addr", addr, 8'h10);
        check("t1_q", q, 8'hA5);
        model_mem[8'h10] = 8'hA5;
        model_addr = 8'h10;

        // Full-depth fill, then clean and fully-mismatching (saturating) verifies.
        run_burst(MODE_FILL, 8'h37, 8'd0, 8'h00, 0);
        read_check(8'h36);
        check("t4_last_word", q, 8'hFF);
        run_burst(MODE_VERIFY, 8'h37, 8'd0, 8'h00, 0);
        run_burst(MODE_VERIFY, 8'h37, 8'd0, 8'h01, 0);

        // Wrapping 4-word fill, readback, corrupted and clean verifies.
        run_burst(MODE_FILL, 8'hFE, 8'd4, 8'h20, 0);
        read_check(8'hFE); read_check(8'hFF); read_check(8'h00); read_check(8'h01);
        manual_step(1'b1, 1'b0, 1'b0, 8'hFF);
        manual_step(1'b0, 1'b0, 1'b1, 8'h00);
        model_mem[8'hFF] = 8'h00;
        run_burst(MODE_VERIFY, 8'hFE, 8'd4, 8'h20, 0);
        manual_step(1'b1, 1'b0, 1'b0, 8'hFF);
        manual_step(1'b0, 1'b0, 1'b1, 8'h21);
        model_mem[8'hFF] = 8'h21;
        run_burst(MODE_VERIFY, 8'hFE, 8'd4, 8'h20, 0);

        // Aborts on the third busy cycle.
        run_burst(MODE_FILL, 8'h80, 8'd8, 8'h55, 3);
        read_check(8'h81);
        read_check(8'h82);
        run_burst(MODE_VERIFY, 8'hFE, 8'd4, 8'h07, 3);

        // Random fill/verify pairs, some with aborts or a wrong seed.
        b = '0; l = 8'd1; s = '0;
        for (int n = 0; n < 16; n++) begin
            if (n % 2 == 0) begin
                m = MODE_FILL;
                b = 8'($urandom);
                l = 8'($urandom_range(1, 24));
                s = 8'($urandom);
                vs = s;
            end else begin
                m = MODE_VERIFY;
                vs = ($urandom_range(0, 2) == 0) ? s + 8'd1 : s;
            end
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, int'(l)) : 0;
            run_burst(m, b, l, vs, k);
        end

        manual_ops(60);

        // Asynchronous reset in the middle of a verify with cmd_start held high.
        manual_step(1'b1, 1'b0, 1'b0, 8'h40);
        cmd_start = 1'b1; cmd_mode = MODE_VERIFY; burst_len = 8'd0; din = 8'hC3;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            cmd_mode = 1'($urandom); burst_len = 8'($urandom); din = 8'($urandom);
            @(posedge clk); #1;
        end
        check("t6_busy_before_reset", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_addr", addr, 0);
        check("t6_err_cnt", err_cnt, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_q", q, 0);
        clear_inputs();
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_addr = '0;
        model_err  = 0;
        @(posedge clk); #1;
        run_burst(MODE_VERIFY, 8'hFE, 8'd4, 8'h20, 0);
        read_check(8'h10);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
